// File: rtl/rob_ctrl.sv
// rob_ctrl: in-order reorder buffer control with tagged allocation, CDB completion, commit and mispredict rollback
module rob_ctrl #(
  parameter int ROB_BIT = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               iss_ena,
  input  logic [4:0]         iss_rd,
  input  logic               iss_is_br,
  input  logic               iss_is_st,
  output logic [ROB_BIT-1:0] alloc_idx,
  output logic               full,
  output logic               empty,
  input  logic               cdb_ena,
  input  logic [ROB_BIT-1:0] cdb_idx,
  input  logic [31:0]        cdb_val,
  input  logic               cdb_mispred,
  input  logic [31:0]        cdb_tgt,
  output logic               rob_wr_ena,
  output logic [4:0]         rob_wr_rd,
  output logic [31:0]        rob_wr_val,
  output logic [ROB_BIT-1:0] rob_wr_idx,
  output logic               commit_st,
  output logic               rb,
  output logic [31:0]        rb_pc
);
  localparam int ROB_SIZE = 1 << ROB_BIT;
  localparam logic [ROB_BIT-1:0] ZERO_ROB_IDX = '0;
  localparam logic [ROB_BIT-1:0] ONE = ROB_BIT'(1);
  localparam logic [ROB_BIT-1:0] LAST = ROB_BIT'(ROB_SIZE - 1);
  logic [ROB_SIZE-1:0] busy, ready, is_br, is_st, mispred;
  logic [4:0]          rd_q  [ROB_SIZE];
  logic [31:0]         val_q [ROB_SIZE];
  logic [31:0]         tgt_q [ROB_SIZE];
  logic [ROB_BIT-1:0]  head, tail, count;
  logic                do_alloc, do_commit, do_rb, cdb_hit;
  // Tag 0 means "no producer", so both pointers wrap from LAST back to 1.
  function automatic logic [ROB_BIT-1:0] nxt(input logic [ROB_BIT-1:0] x);
    return x == LAST ? ONE : x + ONE;
  endfunction
  assign alloc_idx = tail;
  assign full      = count == LAST;
  assign empty     = count == '0;
  assign do_alloc  = rdy && iss_ena && !full;
  assign do_commit = rdy && busy[head] && ready[head];
  assign do_rb     = do_commit && is_br[head] && mispred[head];
  assign cdb_hit   = rdy && cdb_ena && cdb_idx != ZERO_ROB_IDX && busy[cdb_idx];
  always_ff @(posedge clk) begin
    if (rst) begin
      head       <= ONE;
      tail       <= ONE;
      count      <= '0;
      busy       <= '0;
      ready      <= '0;
      rob_wr_ena <= 1'b0;
      rob_wr_rd  <= '0;
      rob_wr_val <= '0;
      rob_wr_idx <= '0;
      commit_st  <= 1'b0;
      rb         <= 1'b0;
      rb_pc      <= '0;
    end else begin
      rob_wr_ena <= do_commit && rd_q[head] != 5'd0;
      rob_wr_rd  <= do_commit ? rd_q[head] : 5'd0;
      rob_wr_val <= do_commit ? val_q[head] : 32'd0;
      rob_wr_idx <= do_commit ? head : ZERO_ROB_IDX;
      commit_st  <= do_commit && is_st[head];
      rb         <= do_rb;
      rb_pc      <= do_rb ? tgt_q[head] : 32'd0;
      if (do_rb) begin
        busy  <= '0;
        ready <= '0;
        head  <= ONE;
        tail  <= ONE;
        count <= '0;
      end else if (rdy) begin
        if (cdb_hit) begin
          ready[cdb_idx]   <= 1'b1;
          val_q[cdb_idx]   <= cdb_val;
          mispred[cdb_idx] <= cdb_mispred;
          tgt_q[cdb_idx]   <= cdb_tgt;
        end
        if (do_commit) begin
          busy[head]  <= 1'b0;
          ready[head] <= 1'b0;
          head        <= nxt(head);
        end
        if (do_alloc) begin
          busy[tail]    <= 1'b1;
          ready[tail]   <= 1'b0;
          mispred[tail] <= 1'b0;
          rd_q[tail]    <= iss_rd;
          is_br[tail]   <= iss_is_br;
          is_st[tail]   <= iss_is_st;
          tail          <= nxt(tail);
        end
        count <= count + ROB_BIT'(do_alloc) - ROB_BIT'(do_commit);
      end
    end
  end
endmodule

// File: tb/tb_rob_ctrl.sv
// tb_rob_ctrl: directed scenarios checked every cycle against a queue-based ROB model
module tb_rob_ctrl;
  localparam int RB = 3;
  localparam int SZ = 1 << RB;
  logic clk = 0, rst = 1, rdy = 1;
  logic iss_ena = 0, iss_is_br = 0, iss_is_st = 0;
  logic [4:0] iss_rd = 0;
  logic cdb_ena = 0, cdb_mispred = 0;
  logic [RB-1:0] cdb_idx = 0;
  logic [31:0] cdb_val = 0, cdb_tgt = 0;
  logic [RB-1:0] alloc_idx, rob_wr_idx;
  logic full, empty, rob_wr_ena, commit_st, rb;
  logic [4:0] rob_wr_rd;
  logic [31:0] rob_wr_val, rb_pc;
  rob_ctrl #(.ROB_BIT(RB)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .iss_ena(iss_ena), .iss_rd(iss_rd),
    .iss_is_br(iss_is_br), .iss_is_st(iss_is_st), .alloc_idx(alloc_idx),
    .full(full), .empty(empty), .cdb_ena(cdb_ena), .cdb_idx(cdb_idx),
    .cdb_val(cdb_val), .cdb_mispred(cdb_mispred), .cdb_tgt(cdb_tgt),
    .rob_wr_ena(rob_wr_ena), .rob_wr_rd(rob_wr_rd), .rob_wr_val(rob_wr_val),
    .rob_wr_idx(rob_wr_idx), .commit_st(commit_st), .rb(rb), .rb_pc(rb_pc)
  );
  always #5 clk = ~clk;
  typedef struct {
    int tag; int rd; bit br; bit st; bit done; bit mis; logic [31:0] val; logic [31:0] tgt;
  } ent_t;
  ent_t q[$];
  int m_tail = 1;
  bit e_wr, e_st, e_rb;
  int e_rd, e_idx;
  logic [31:0] e_val, e_pc;
  int pass_n = 0, total_n = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask
  // Advances the model by one clock using the inputs currently driven.
  task automatic model_step;
    bit commit, alloc_ok;
    e_wr = 0; e_st = 0; e_rb = 0; e_rd = 0; e_idx = 0; e_val = 0; e_pc = 0;
    if (rst) begin
      q.delete();
      m_tail = 1;
    end else if (rdy) begin
      commit = q.size() > 0 && q[0].done;
      alloc_ok = iss_ena && q.size() < SZ - 1;
      if (commit) begin
        e_wr = q[0].rd != 0; e_st = q[0].st; e_rd = q[0].rd; e_idx = q[0].tag; e_val = q[0].val;
        if (q[0].br && q[0].mis) begin e_rb = 1; e_pc = q[0].tgt; end
      end
      if (e_rb) begin
        q.delete();
        m_tail = 1;
      end else begin
        if (cdb_ena)
          foreach (q[i]) if (q[i].tag == int'(cdb_idx)) begin
            q[i].done = 1; q[i].val = cdb_val; q[i].mis = cdb_mispred; q[i].tgt = cdb_tgt;
          end
        if (commit) void'(q.pop_front());
        if (alloc_ok) begin
          q.push_back('{m_tail, int'(iss_rd), iss_is_br, iss_is_st, 1'b0, 1'b0, 32'd0, 32'd0});
          m_tail = m_tail == SZ - 1 ? 1 : m_tail + 1;
        end
      end
    end
  endtask
  task automatic cyc;
    model_step();
    @(posedge clk);
    #1;
    chk("full", full, q.size() == SZ - 1);
    chk("empty", empty, q.size() == 0);
    chk("alloc_idx", alloc_idx, m_tail);
    chk("rob_wr_ena", rob_wr_ena, e_wr);
    chk("commit_st", commit_st, e_st);
    chk("rb", rb, e_rb);
    if (e_wr || e_st) begin
      chk("rob_wr_rd", rob_wr_rd, e_rd);
      chk("rob_wr_val", rob_wr_val, e_val);
      chk("rob_wr_idx", rob_wr_idx, e_idx);
    end
    if (e_rb) chk("rb_pc", rb_pc, e_pc);
  endtask
  task automatic idle;
    iss_ena = 0; cdb_ena = 0; iss_is_br = 0; iss_is_st = 0; cdb_mispred = 0;
  endtask
  task automatic reset_dut;
    idle(); rst = 1; cyc(); rst = 0;
  endtask
  task automatic issue(input int rd, input bit br, input bit st);
    idle(); iss_ena = 1; iss_rd = 5'(rd); iss_is_br = br; iss_is_st = st; cyc(); idle();
  endtask
  task automatic cdb(input int idx, input logic [31:0] v, input bit mis, input logic [31:0] t);
    idle(); cdb_ena = 1; cdb_idx = RB'(idx); cdb_val = v; cdb_mispred = mis; cdb_tgt = t; cyc(); idle();
  endtask
  initial begin
    rst = 1; cyc(); cyc(); rst = 0;
    chk("rst alloc_idx", alloc_idx, 1);
    chk("rst empty", empty, 1);
    chk("rst outputs", {rob_wr_ena, rob_wr_rd, rob_wr_val, rob_wr_idx, commit_st, rb, rb_pc, full}, 0);
    issue(5, 0, 0);
    chk("first alloc_idx", alloc_idx, 2);
    cdb(1, 32'h1234, 0, 0);
    chk("no same-cycle commit", rob_wr_ena, 0);
    cyc();
    chk("commit ena", rob_wr_ena, 1);
    chk("commit rd", rob_wr_rd, 5);
    chk("commit val", rob_wr_val, 32'h1234);
    chk("commit idx", rob_wr_idx, 1);
    chk("empty after commit", empty, 1);
    cyc();
    chk("pulse one cycle", rob_wr_ena, 0);
    reset_dut();
    for (int i = 1; i <= 7; i++) issue(i, 0, 0);
    chk("full after 7", full, 1);
    chk("alloc_idx wrapped", alloc_idx, 1);
    issue(8, 0, 0);
    chk("ignored 8th", alloc_idx, 1);
    cdb(1, 32'h11, 0, 0);
    cyc();
    chk("full cleared", full, 0);
    cdb(0, 32'hdead, 0, 0);
    cyc();
    reset_dut();
    for (int i = 1; i <= 3; i++) issue(i, 0, 0);
    cdb(3, 32'h33, 0, 0);
    cdb(2, 32'h22, 0, 0);
    cdb(1, 32'h11, 0, 0);
    cyc(); chk("ooo first", rob_wr_idx, 1);
    cyc(); chk("ooo second", rob_wr_idx, 2);
    cyc(); chk("ooo third", rob_wr_idx, 3);
    chk("ooo third val", rob_wr_val, 32'h33);
    reset_dut();
    issue(1, 0, 0); issue(0, 1, 0); issue(3, 0, 0); issue(4, 0, 0);
    cdb(2, 32'h0, 1, 32'h100);
    cdb(1, 32'haa, 0, 0);
    cyc();
    chk("pre-rb commit", rob_wr_idx, 1);
    iss_ena = 1; iss_rd = 9;
    cyc();
    chk("rb pulse", rb, 1);
    chk("rb_pc", rb_pc, 32'h100);
    cdb(3, 32'h77, 0, 0);
    chk("rb empty", empty, 1);
    chk("rb alloc_idx", alloc_idx, 1);
    cyc(); cyc();
    chk("late cdb ignored", rob_wr_ena, 0);
    reset_dut();
    issue(0, 0, 1); issue(2, 0, 0); issue(3, 0, 0);
    cdb(1, 32'h5, 0, 0);
    iss_ena = 1; iss_rd = 4;
    cyc(); idle();
    chk("store commit_st", commit_st, 1);
    chk("store wr_ena", rob_wr_ena, 0);
    chk("alloc+commit idx", alloc_idx, 5);
    for (int i = 0; i < 3; i++) issue(10 + i, 0, 0);
    chk("count held (not full)", full, 0);
    issue(20, 0, 0);
    chk("count held (full)", full, 1);
    reset_dut();
    issue(9, 0, 0);
    cdb(1, 32'h99, 0, 0);
    rdy = 0; iss_ena = 1; iss_rd = 3; cdb_ena = 1; cdb_idx = 2;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("frozen no pulse", rob_wr_ena, 0);
      chk("frozen alloc_idx", alloc_idx, 2);
    end
    rdy = 1; idle();
    cyc();
    chk("thaw commit", rob_wr_ena, 1);
    chk("thaw idx", rob_wr_idx, 1);
    issue(6, 0, 0);
    cdb(2, 32'h66, 0, 0);
    rst = 1; cyc(); rst = 0;
    chk("mid rst no pulse", rob_wr_ena, 0);
    chk("mid rst empty", empty, 1);
    cyc();
    chk("mid rst stays quiet", rob_wr_ena, 0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
